// File: rtl/memory_responder.sv
// Fixed-latency block memory model answering cache fill/write-back requests.
// Transfers one 4-byte block per request and pulses mem_ready when it completes.
module memory_responder #(
    parameter int unsigned LATENCY   = 4,
    parameter int unsigned ADDR_BITS = 12
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            mem_req,
    input  logic            mem_write,
    input  logic [31:0]     mem_addr,
    input  logic [0:3][7:0] mem_data_in,
    output logic [0:3][7:0] mem_data_out,
    output logic            mem_ready,
    output logic            mem_busy
);

    localparam int unsigned WORDS = 2 ** (ADDR_BITS - 2);

    typedef enum logic [1:0] {IDLE, WAIT, RESPOND} state_t;

    state_t                 state;
    logic [3:0]             count;
    logic                   write_q;
    logic [ADDR_BITS-3:0]   index_q;
    logic [0:3][7:0]        data_q;
    logic [0:3][7:0]        storage [WORDS];
    logic                   commit;

    // Byte-offset bits and bits above the storage size are dropped, so addresses alias.
    logic addr_unused;
    assign addr_unused = ^{mem_addr[31:ADDR_BITS], mem_addr[1:0]};

    always_comb begin
        commit = (state == WAIT) && (count == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            count        <= '0;
            mem_ready    <= 1'b0;
            mem_busy     <= 1'b0;
            mem_data_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    mem_ready <= 1'b0;
                    if (mem_req) begin
                        write_q  <= mem_write;
                        index_q  <= mem_addr[ADDR_BITS-1:2];
                        data_q   <= mem_data_in;
                        count    <= 4'(LATENCY - 1);
                        state    <= WAIT;
                        mem_busy <= 1'b1;
                    end
                end
                WAIT: begin
                    if (count != '0) begin
                        count <= count - 4'd1;
                    end else begin
                        if (!write_q) begin
                            mem_data_out <= storage[index_q];
                        end
                        state     <= RESPOND;
                        mem_ready <= 1'b1;
                    end
                end
                RESPOND: begin
                    state     <= IDLE;
                    mem_ready <= 1'b0;
                    mem_busy  <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    mem_ready <= 1'b0;
                    mem_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Storage has no reset; a write lands at the WAIT-exit edge unless reset wins that edge.
    always_ff @(posedge clk) begin
        if (!reset && commit && write_q) begin
            storage[index_q] <= data_q;
        end
    end

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: LATENCY=4 instance for the main vectors,
// LATENCY=1 instance for the minimum-latency back-to-back case.
module tb_memory_responder;

    localparam int unsigned L4 = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            req, wr;
    logic [31:0]     addr;
    logic [0:3][7:0] din, dout;
    logic            ready, busy;
    logic            req1, wr1;
    logic [31:0]     addr1;
    logic [0:3][7:0] din1, dout1;
    logic            ready1, busy1;

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [31:0] last_read;

    always #5 clk = ~clk;

    memory_responder #(.LATENCY(L4), .ADDR_BITS(12)) dut (
        .clk(clk), .reset(reset), .mem_req(req), .mem_write(wr), .mem_addr(addr),
        .mem_data_in(din), .mem_data_out(dout), .mem_ready(ready), .mem_busy(busy)
    );

    memory_responder #(.LATENCY(1), .ADDR_BITS(12)) dut1 (
        .clk(clk), .reset(reset), .mem_req(req1), .mem_write(wr1), .mem_addr(addr1),
        .mem_data_in(din1), .mem_data_out(dout1), .mem_ready(ready1), .mem_busy(busy1)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One full transaction on the LATENCY=4 instance, checking every cycle.
    task automatic do_txn(input vec_t v);
        logic [31:0] exp_out;
        req = 1'b1; wr = v.wr; addr = v.addr; din = v.data;
        tick;
        req = 1'b0; wr = ~v.wr; addr = $urandom; din = $urandom;
        chk("busy_accept", 32'(busy), 32'd1);
        chk("ready_early", 32'(ready), 32'd0);
        for (int i = 1; i < int'(L4); i++) begin
            tick;
            chk("ready_wait", 32'(ready), 32'd0);
            chk("busy_wait", 32'(busy), 32'd1);
            chk("dout_hold", dout, last_read);
        end
        tick;
        exp_out = v.wr ? last_read : v.exp;
        chk("ready_pulse", 32'(ready), 32'd1);
        chk("busy_respond", 32'(busy), 32'd1);
        chk("dout_respond", dout, exp_out);
        last_read = exp_out;
        tick;
        chk("ready_end", 32'(ready), 32'd0);
        chk("busy_end", 32'(busy), 32'd0);
    endtask

    initial begin
        int unsigned pulses;
        int          prev;

        vecs[0] = '{1'b1, 32'h0000_0010, 32'h11223344, 32'h0};
        vecs[1] = '{1'b0, 32'h0000_0012, 32'h0,        32'h11223344};
        vecs[2] = '{1'b1, 32'h0000_1010, 32'hAABBCCDD, 32'h0};
        vecs[3] = '{1'b0, 32'h0000_0010, 32'h0,        32'hAABBCCDD};
        vecs[4] = '{1'b1, 32'h0000_0020, 32'h01020304, 32'h0};
        vecs[5] = '{1'b0, 32'h0000_0023, 32'h0,        32'h01020304};
        vecs[6] = '{1'b1, 32'h0000_07FC, 32'h5AA5C33C, 32'h0};
        vecs[7] = '{1'b0, 32'hFFFF_F7FC, 32'h0,        32'h5AA5C33C};

        reset = 1'b1;
        req = 1'b0; wr = 1'b0; addr = '0; din = '0;
        req1 = 1'b0; wr1 = 1'b0; addr1 = '0; din1 = '0;
        tick; tick;
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_dout", dout, 32'h0);

        // Reset wins over a simultaneous request.
        req = 1'b1; wr = 1'b0; addr = 32'h10;
        tick;
        chk("rst_prio_busy", 32'(busy), 32'd0);
        reset = 1'b0; req = 1'b0;
        tick;
        chk("rst_prio_idle", 32'(busy), 32'd0);
        last_read = 32'h0;

        for (int i = 0; i < 8; i++) do_txn(vecs[i]);

        // Reset during WAIT abandons a write to 0x20.
        req = 1'b1; wr = 1'b1; addr = 32'h20; din = 32'hDEADBEEF;
        tick;
        req = 1'b0;
        tick;
        reset = 1'b1;
        tick;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ready", 32'(ready), 32'd0);
        chk("abort_dout", dout, 32'h0);
        reset = 1'b0;
        last_read = 32'h0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick;
            if (ready) pulses++;
        end
        chk("abort_no_ready", pulses, 32'd0);
        do_txn('{1'b0, 32'h20, 32'h0, 32'h01020304});

        // Reset in RESPOND keeps the committed write.
        req = 1'b1; wr = 1'b1; addr = 32'h30; din = 32'h12345678;
        tick;
        req = 1'b0;
        tick; tick; tick; tick;
        chk("rsp_rst_ready", 32'(ready), 32'd1);
        reset = 1'b1;
        tick;
        chk("rsp_rst_ready_low", 32'(ready), 32'd0);
        chk("rsp_rst_busy", 32'(busy), 32'd0);
        chk("rsp_rst_dout", dout, 32'h0);
        reset = 1'b0;
        last_read = 32'h0;
        do_txn('{1'b0, 32'h30, 32'h0, 32'h12345678});

        // Held read request: pulses every LATENCY+2 cycles, address wiggles while busy.
        req = 1'b1; wr = 1'b0; addr = 32'h10;
        pulses = 0;
        prev = -1;
        for (int i = 1; i <= 40; i++) begin
            tick;
            if (ready) begin
                chk("held_dout", dout, 32'hAABBCCDD);
                if (prev >= 0) chk("held_gap", 32'(i - prev), 32'(L4 + 2));
                prev = i;
                pulses++;
            end
            addr = busy ? 32'h20 : 32'h10;
        end
        req = 1'b0;
        chk("held_pulses", pulses, 32'd6);
        for (int i = 0; i < 10 && (busy || ready); i++) tick;
        chk("held_drain", 32'(busy), 32'd0);
        last_read = 32'hAABBCCDD;

        // LATENCY=1: write then back-to-back read accepted at edge k+3.
        req1 = 1'b1; wr1 = 1'b1; addr1 = 32'h4; din1 = 32'hC0FFEE11;
        tick;
        wr1 = 1'b0; din1 = '0;
        chk("l1_busy_k", 32'(busy1), 32'd1);
        chk("l1_ready_k", 32'(ready1), 32'd0);
        tick;
        chk("l1_ready_k1", 32'(ready1), 32'd1);
        chk("l1_dout_k1", dout1, 32'h0);
        tick;
        chk("l1_ready_k2", 32'(ready1), 32'd0);
        chk("l1_busy_k2", 32'(busy1), 32'd0);
        tick;
        chk("l1_busy_k3", 32'(busy1), 32'd1);
        req1 = 1'b0;
        tick;
        chk("l1_ready_k4", 32'(ready1), 32'd1);
        chk("l1_dout_k4", dout1, 32'hC0FFEE11);
        tick;
        chk("l1_idle", 32'(busy1), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
